// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin APB master front-end
// Optional macro APB_TIMEOUT_EN bounds ACCESS wait states to TIMEOUT_CYC cycles.
module apb_req_arbiter #(
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic [1:0]        REQ_VALID,
   input  logic [1:0]        REQ_WRITE,
   input  logic [ADDR_W-1:0] REQ_ADDR0,
   input  logic [ADDR_W-1:0] REQ_ADDR1,
   input  logic [DATA_W-1:0] REQ_WDATA0,
   input  logic [DATA_W-1:0] REQ_WDATA1,
   output logic [1:0]        REQ_DONE,
   output logic [DATA_W-1:0] RSP_RDATA,
   output logic              RSP_ERR,
   output logic [1:0]        PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PSLVERR
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   state_t            r_state;
   logic              r_ptr;
   logic              r_win;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic [1:0]        r_psel;
   logic              r_penable;
   logic [1:0]        r_done;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0]  r_wait_cnt;
`endif

   logic [1:0]        w_win_oh;
   logic [1:0]        w_elig;
   logic              w_any;
   logic              w_pick;
   logic              w_pick_write;
   logic [ADDR_W-1:0] w_pick_addr;
   logic [DATA_W-1:0] w_pick_wdata;
   logic [1:0]        w_pick_sel;

   // A requester keeps REQ_VALID high through its completion edge and the
   // REQ_DONE cycle, so those bits must not start a duplicate transfer.
   always_comb begin
      w_win_oh     = r_win ? 2'b10 : 2'b01;
      w_elig       = REQ_VALID & ~r_done & ((r_state == S_ACCESS) ? ~w_win_oh : 2'b11);
      w_any        = |w_elig;
      w_pick       = (w_elig == 2'b11) ? r_ptr : w_elig[1];
      w_pick_write = w_pick ? REQ_WRITE[1] : REQ_WRITE[0];
      w_pick_addr  = w_pick ? REQ_ADDR1 : REQ_ADDR0;
      w_pick_wdata = w_pick ? REQ_WDATA1 : REQ_WDATA0;
      w_pick_sel   = w_pick_addr[ADDR_W-1] ? 2'b10 : 2'b01;
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state    <= S_IDLE;
         r_ptr      <= 1'b0;
         r_win      <= 1'b0;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
         r_psel     <= 2'b00;
         r_penable  <= 1'b0;
         r_done     <= 2'b00;
`ifdef APB_TIMEOUT_EN
         r_wait_cnt <= '0;
`endif
      end else begin
         r_done <= 2'b00;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_win     <= w_pick;
                  r_write   <= w_pick_write;
                  r_addr    <= w_pick_addr;
                  r_wdata   <= w_pick_wdata;
                  r_psel    <= w_pick_sel;
                  r_penable <= 1'b0;
                  r_state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_penable  <= 1'b1;
               r_state    <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
               r_wait_cnt <= '0;
`endif
            end
            S_ACCESS: begin
               if (PREADY) begin
                  r_rdata   <= r_write ? '0 : PRDATA;
                  r_err     <= PSLVERR;
                  r_done    <= w_win_oh;
                  r_ptr     <= ~r_win;
                  r_penable <= 1'b0;
                  if (w_any) begin
                     r_win   <= w_pick;
                     r_write <= w_pick_write;
                     r_addr  <= w_pick_addr;
                     r_wdata <= w_pick_wdata;
                     r_psel  <= w_pick_sel;
                     r_state <= S_SETUP;
                  end else begin
                     r_psel  <= 2'b00;
                     r_state <= S_IDLE;
                  end
               end
`ifdef APB_TIMEOUT_EN
               else if (r_wait_cnt == CNT_LAST) begin
                  r_rdata   <= '0;
                  r_err     <= 1'b1;
                  r_done    <= w_win_oh;
                  r_ptr     <= ~r_win;
                  r_psel    <= 2'b00;
                  r_penable <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
`endif
            end
            default: begin
               r_psel    <= 2'b00;
               r_penable <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign REQ_DONE  = r_done;
   assign RSP_RDATA = r_rdata;
   assign RSP_ERR   = r_err;
   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign PWRITE    = r_write;
   assign PADDR     = r_addr;
   assign PWDATA    = r_wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter
// Set APB_TIMEOUT_EN to also exercise the wait-state timeout.
module tb_apb_req_arbiter;

   typedef struct {
      int          idx;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic        v0 = 1'b0, v1 = 1'b0;
   logic        w0 = 1'b0, w1 = 1'b0;
   logic [4:0]  a0 = '0, a1 = '0;
   logic [31:0] d0 = '0, d1 = '0;
   logic        PREADY = 1'b0;
   logic [31:0] PRDATA = '0;
   logic        PSLVERR = 1'b0;

   logic [1:0]  REQ_DONE;
   logic [31:0] RSP_RDATA;
   logic        RSP_ERR;
   logic [1:0]  PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [4:0]  PADDR;
   logic [31:0] PWDATA;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          sl_wait = 0;
   logic [31:0] sl_rdata = '0;
   logic        sl_err = 1'b0;
   int          acc_cnt = 0;
   exp_t        sb[$];
   int          done_cyc[$];
   exp_t        e;

   apb_req_arbiter #(.ADDR_W(5), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .REQ_VALID  ({v1, v0}),
      .REQ_WRITE  ({w1, w0}),
      .REQ_ADDR0  (a0),
      .REQ_ADDR1  (a1),
      .REQ_WDATA0 (d0),
      .REQ_WDATA1 (d1),
      .REQ_DONE   (REQ_DONE),
      .RSP_RDATA  (RSP_RDATA),
      .RSP_ERR    (RSP_ERR),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .PREADY     (PREADY),
      .PRDATA     (PRDATA),
      .PSLVERR    (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   always @(posedge PCLK) cyc++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input int idx, input logic [31:0] rd, input logic err);
      exp_t x;
      x.idx = idx;
      x.rdata = rd;
      x.err = err;
      sb.push_back(x);
   endtask

   // Slave: holds PREADY low for sl_wait ACCESS cycles, then completes.
   always @(posedge PCLK) begin
      #1;
      if (PSEL != 2'b00 && PENABLE) begin
         PREADY = (acc_cnt >= sl_wait);
         acc_cnt++;
      end else begin
         PREADY = 1'b0;
         acc_cnt = 0;
      end
      PRDATA = sl_rdata;
      PSLVERR = sl_err;
   end

   always @(negedge PCLK) begin
      if (!PRESET && REQ_DONE != 2'b00) begin
         done_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            chk("sb_unexpected_done", {30'd0, REQ_DONE}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_done", {30'd0, REQ_DONE}, (e.idx == 0) ? 32'd1 : 32'd2);
            chk("sb_rdata", RSP_RDATA, e.rdata);
            chk("sb_err", {31'd0, RSP_ERR}, {31'd0, e.err});
         end
      end
   end

   task automatic do_req(input int idx, input logic wr, input logic [4:0] a,
                         input logic [31:0] d, input bit keep);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      if (idx == 0) begin w0 = wr; a0 = a; d0 = d; v0 = 1'b1; end
      else          begin w1 = wr; a1 = a; d1 = d; v1 = 1'b1; end
      while (!seen && n < 64) begin
         @(negedge PCLK);
         n++;
         if (REQ_DONE[idx]) seen = 1'b1;
      end
      chk($sformatf("req%0d_done_seen", idx), {31'd0, seen}, 32'd1);
      @(posedge PCLK);
      #1;
      if (!keep) begin
         if (idx == 0) v0 = 1'b0;
         else          v1 = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt;
      bit seen;

      // Reset state
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_psel", {30'd0, PSEL}, 32'd0);
      chk("rst_penable", {31'd0, PENABLE}, 32'd0);
      chk("rst_done", {30'd0, REQ_DONE}, 32'd0);
      chk("rst_paddr", {27'd0, PADDR}, 32'd0);
      chk("rst_rdata", RSP_RDATA, 32'd0);
      @(posedge PCLK); #1 PRESET = 1'b0;
      repeat (2) @(posedge PCLK); #1;

      // Single write, zero wait states
      sl_wait = 0; sl_err = 1'b0; sl_rdata = 32'h5555AAAA;
      push_exp(0, 32'd0, 1'b0);
      w0 = 1'b1; a0 = 5'h03; d0 = 32'hDEADBEEF; v0 = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      chk("wr_setup_psel", {30'd0, PSEL}, 32'd1);
      chk("wr_setup_penable", {31'd0, PENABLE}, 32'd0);
      chk("wr_pwdata", PWDATA, 32'hDEADBEEF);
      chk("wr_pwrite", {31'd0, PWRITE}, 32'd1);
      chk("wr_paddr", {27'd0, PADDR}, 32'h03);
      @(negedge PCLK);
      chk("wr_access_psel", {30'd0, PSEL}, 32'd1);
      chk("wr_access_penable", {31'd0, PENABLE}, 32'd1);
      @(negedge PCLK);
      chk("wr_done_latency", {30'd0, REQ_DONE}, 32'd1);
      chk("wr_psel_dropped", {30'd0, PSEL}, 32'd0);
      @(posedge PCLK); #1 v0 = 1'b0;
      repeat (2) @(posedge PCLK); #1;

      // Read from requester 1 with three wait states
      sl_wait = 3; sl_rdata = 32'h00C0FFEE;
      push_exp(1, 32'h00C0FFEE, 1'b0);
      w1 = 1'b0; a1 = 5'h12; d1 = 32'd0; v1 = 1'b1;
      cnt = 0; seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge PCLK);
         if (PSEL == 2'b10) cnt++;
         if (REQ_DONE[1]) seen = 1'b1;
      end
      chk("rd_done_seen", {31'd0, seen}, 32'd1);
      chk("rd_psel_cycles", cnt, 32'd5);
      @(posedge PCLK); #1 v1 = 1'b0;
      repeat (2) @(posedge PCLK); #1;

      // Contention: both requesters valid, four back-to-back transfers
      sl_wait = 0; sl_rdata = 32'hA5A50001;
      done_cyc.delete();
      push_exp(0, 32'd0, 1'b0);
      push_exp(1, 32'hA5A50001, 1'b0);
      push_exp(0, 32'hA5A50001, 1'b0);
      push_exp(1, 32'd0, 1'b0);
      fork
         begin
            do_req(0, 1'b1, 5'h01, 32'h11111111, 1'b1);
            do_req(0, 1'b0, 5'h11, 32'd0, 1'b0);
         end
         begin
            do_req(1, 1'b0, 5'h04, 32'd0, 1'b1);
            do_req(1, 1'b1, 5'h15, 32'h22222222, 1'b0);
         end
      join
      chk("b2b_count", done_cyc.size(), 32'd4);
      for (int i = 1; i < done_cyc.size(); i++)
         chk($sformatf("b2b_gap%0d", i), done_cyc[i] - done_cyc[i-1], 32'd2);
      repeat (3) @(posedge PCLK); #1;

      // Slave error on a write, then a clean read
      sl_wait = 1; sl_err = 1'b1;
      push_exp(0, 32'd0, 1'b1);
      do_req(0, 1'b1, 5'h1F, 32'hCAFEF00D, 1'b0);
      sl_err = 1'b0; sl_wait = 0; sl_rdata = 32'h12345678;
      push_exp(1, 32'h12345678, 1'b0);
      do_req(1, 1'b0, 5'h02, 32'd0, 1'b0);
      repeat (2) @(posedge PCLK); #1;

`ifdef APB_TIMEOUT_EN
      // Slave never ready: forced completion with error
      sl_wait = 1000; sl_rdata = 32'hBAD0BAD0;
      push_exp(0, 32'd0, 1'b1);
      do_req(0, 1'b0, 5'h05, 32'd0, 1'b0);
      chk("to_psel_idle", {30'd0, PSEL}, 32'd0);
      chk("to_penable_idle", {31'd0, PENABLE}, 32'd0);
      sl_wait = 0;
      repeat (2) @(posedge PCLK); #1;
`endif

      // Reset during an ACCESS wait state
      sl_wait = 20;
      w1 = 1'b0; a1 = 5'h08; v1 = 1'b1;
      repeat (3) @(negedge PCLK);
      chk("rst_mid_access", {31'd0, PENABLE}, 32'd1);
      #1 PRESET = 1'b1; v1 = 1'b0;
      #1;
      chk("rst_mid_psel", {30'd0, PSEL}, 32'd0);
      chk("rst_mid_penable", {31'd0, PENABLE}, 32'd0);
      chk("rst_mid_done", {30'd0, REQ_DONE}, 32'd0);
      @(posedge PCLK); #1 PRESET = 1'b0;
      @(posedge PCLK); #1;

      // After reset both valid: requester 0 must win first
      sl_wait = 0; sl_rdata = 32'h0BADCAFE;
      push_exp(0, 32'h0BADCAFE, 1'b0);
      push_exp(1, 32'd0, 1'b0);
      fork
         do_req(0, 1'b0, 5'h0A, 32'd0, 1'b0);
         do_req(1, 1'b1, 5'h1A, 32'h77777777, 1'b0);
      join
      repeat (4) @(posedge PCLK);
      @(negedge PCLK);
      chk("sb_leftover", sb.size(), 32'd0);
      chk("end_idle_psel", {30'd0, PSEL}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
